serial_subtractor: RTL

Parametrised multi-cycle unsigned/two's-complement subtractor computing D = X − Y − Bin over WIDTH bits, DIGIT bits per clock, with a borrow register carrying between digits. It is the sequential successor of the single-bit half-subtractor cell. It sits between a valid/ready operand source and a valid/ready result sink, and trades latency for a narrow DIGIT-wide subtract datapath.

---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor_fs.sv | 12 +
 rtl/serial_subtractor.sv | 105 ++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// State encoding plus the digit-counter width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result valid-ready bundle for serial_subtractor.
// master = operand source and result sink; slave = the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, x, y, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );

  modport slave (
    input  in_valid, x, y, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor_fs.sv
// Single-bit full-subtractor cell: d = a - b - bin.
// Chained DIGIT times to form the per-cycle datapath.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = X - Y - Bin, DIGIT bits per clock.
// Result bits enter d at the MSB end, LSB digit first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);

  if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: DIGIT must divide WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;
  logic             x_msb;
  logic             y_msb;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dig;
  logic [WIDTH-1:0] d_next;
  logic             last;

  assign chain[0] = br;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_subtractor u_fs (
      .a    (xs[i]),
      .b    (ys[i]),
      .bin  (chain[i]),
      .d    (dig[i]),
      .bout (chain[i+1])
    );
  end

  assign d_next = (d_q >> DIGIT)
                | (WIDTH'(dig) << (WIDTH - DIGIT));
  assign last   = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      xs     <= '0;
      ys     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      x_msb  <= 1'b0;
      y_msb  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xs    <= bus.x;
            ys    <= bus.y;
            br    <= bus.bin;
            x_msb <= bus.x[WIDTH-1];
            y_msb <= bus.y[WIDTH-1];
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          d_q <= d_next;
          br  <= chain[DIGIT];
          xs  <= xs >> DIGIT;
          ys  <= ys >> DIGIT;
          cnt <= cnt + CW'(1);
          if (last) begin
            bout_q <= chain[DIGIT];
            // overflow only when operand signs differ
            ovf_q  <= (x_msb ^ y_msb) & (dig[DIGIT-1] ^ x_msb);
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule
